// File: rtl/decode_stage.sv
// Registered instruction-decode stage: field split, immediate extension and operand-use flags,
// behind a valid/ready handshake with a two-entry (output + skid) buffer and synchronous flush.
module decode_stage #(
  parameter int XLEN        = 32,
  parameter int DATA_W      = 32,
  parameter int OPC_W       = 2,
  parameter int REG_W       = 5,
  parameter int FUNC_W      = 4,
  parameter int SHORT_IMM_W = 16,
  parameter int PC_W        = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_instr,
  input  logic [PC_W-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_W-1:0]     out_pc,
  output logic [OPC_W-1:0]    out_op,
  output logic [REG_W-1:0]    out_rs,
  output logic [REG_W-1:0]    out_rt,
  output logic                out_rs_used,
  output logic                out_rt_used,
  output logic [FUNC_W-1:0]   out_func,
  output logic [DATA_W-1:0]   out_imm
);

  localparam int LONG_W = XLEN - OPC_W - FUNC_W;
  localparam int MID_W  = LONG_W - REG_W;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [OPC_W-1:0]  op;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic              rs_used;
    logic              rt_used;
    logic [FUNC_W-1:0] func;
    logic [DATA_W-1:0] imm;
  } dec_t;

  dec_t              dec;
  dec_t              out_q;
  dec_t              skid_q;
  logic              out_valid_q;
  logic              skid_valid_q;
  logic [LONG_W-1:0] t_field;
  logic [REG_W-1:0]  rs_field;
  logic [REG_W-1:0]  rt_field;
  logic [DATA_W-1:0] imm_mid;
  logic [DATA_W-1:0] imm_short;
  logic [DATA_W-1:0] imm_long;
  logic              accept;
  logic              consume;

  always_comb begin
    t_field   = in_instr[XLEN-OPC_W-1:FUNC_W];
    rs_field  = in_instr[XLEN-OPC_W-1 -: REG_W];
    rt_field  = in_instr[XLEN-OPC_W-REG_W-1 -: REG_W];
    imm_mid   = DATA_W'($signed(t_field[MID_W-1:0]));
    imm_short = DATA_W'($signed(t_field[SHORT_IMM_W-1:0]));
    imm_long  = DATA_W'(t_field);

    dec      = '0;
    dec.pc   = in_pc;
    dec.op   = in_instr[XLEN-1 -: OPC_W];
    dec.func = in_instr[FUNC_W-1:0];
    case (dec.op)
      OPC_W'(0): begin
        dec.rs      = rs_field;
        dec.rs_used = 1'b1;
        dec.imm     = imm_mid;
      end
      OPC_W'(1): begin
        dec.rs      = rs_field;
        dec.rt      = rt_field;
        dec.rs_used = 1'b1;
        dec.rt_used = 1'b1;
        dec.imm     = imm_short;
      end
      OPC_W'(2): dec.imm = imm_long;
      default:   dec.imm = imm_mid;
    endcase
  end

  // The skid entry is only ever filled while the output register is held, so
  // "skid empty" is exactly the condition for having room for one more.
  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & ~skid_valid_q;
  assign consume  = out_valid_q & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (skid_valid_q) begin
      if (consume) begin
        out_q        <= skid_q;
        skid_valid_q <= 1'b0;
      end
    end else if (out_valid_q && !out_ready) begin
      if (accept) begin
        skid_q       <= dec;
        skid_valid_q <= 1'b1;
      end
    end else if (accept) begin
      out_q       <= dec;
      out_valid_q <= 1'b1;
    end else if (consume) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_q.pc;
  assign out_op      = out_q.op;
  assign out_rs      = out_q.rs;
  assign out_rt      = out_q.rt;
  assign out_rs_used = out_q.rs_used;
  assign out_rt_used = out_q.rt_used;
  assign out_func    = out_q.func;
  assign out_imm     = out_q.imm;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: fixed decode vectors, directed handshake corner cases and a random
// stream, all checked against a queue-based reference of the held instructions.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic        out_rs_used, out_rt_used;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [1:0]  out_op;
  logic [4:0]  out_rs, out_rt;
  logic [3:0]  out_func;

  decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
    .out_rs(out_rs), .out_rt(out_rt), .out_rs_used(out_rs_used), .out_rt_used(out_rt_used),
    .out_func(out_func), .out_imm(out_imm)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;
  item_t q[$];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        rsu;
    logic        rtu;
    logic [3:0]  func;
    logic [31:0] imm;
  } vec_t;
  vec_t vt[7];

  logic [81:0] payload;
  assign payload = {out_pc, out_op, out_rs, out_rt, out_rs_used, out_rt_used, out_func, out_imm};

  // Reference decode from the field rules, using plain integer arithmetic.
  function automatic logic [81:0] model(input logic [31:0] instr, input logic [31:0] pc);
    longint w;
    longint opv, rsf, rtf, fn, imm;
    longint rs, rt, ru, tu;
    w   = longint'(instr);
    opv = w / (1 << 30);
    rsf = (w / (1 << 25)) % 32;
    rtf = (w / (1 << 20)) % 32;
    fn  = w % 16;
    rs = 0; rt = 0; ru = 0; tu = 0;
    if (opv == 1) begin
      rs = rsf; rt = rtf; ru = 1; tu = 1;
      imm = (w / 16) % 65536;
      if (imm >= 32768) imm = imm - 65536;
    end else if (opv == 2) begin
      imm = (w / 16) % (1 << 26);
    end else begin
      if (opv == 0) begin
        rs = rsf; ru = 1;
      end
      imm = (w / 16) % (1 << 21);
      if (imm >= (1 << 20)) imm = imm - (1 << 21);
    end
    return {pc, 2'(opv), 5'(rs), 5'(rt), 1'(ru), 1'(tu), 4'(fn), 32'(imm)};
  endfunction

  task automatic check(input string name, input logic [81:0] act, input logic [81:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare DUT against the reference, drive new inputs, advance the reference.
  task automatic step(input logic r, input logic fl, input logic iv, input logic [31:0] instr,
                      input logic [31:0] pc, input logic ordy, output bit acc);
    bit push, pop;
    @(negedge clk);
    check("out_valid", out_valid, q.size() > 0);
    check("in_ready", in_ready, q.size() < 2);
    if (out_valid && q.size() > 0) check("payload", payload, model(q[0].instr, q[0].pc));
    rst = r; flush = fl; in_valid = iv; in_instr = instr; in_pc = pc; out_ready = ordy;
    acc = 1'b0;
    if (r || fl) begin
      q.delete();
    end else begin
      push = iv && (q.size() < 2);
      pop  = ordy && (q.size() > 0);
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{instr, pc});
      acc = push;
    end
  endtask

  task automatic idle(input logic ordy);
    bit a;
    step(0, 0, 0, 32'h0, 32'h0, ordy, a);
  endtask

  logic [31:0] bp[4];

  initial begin
    bit a;
    int idx;
    rst = 1; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;

    vt[0] = '{32'h464FFF05, 32'h100, 2'd1, 5'd3,  5'd4,  1, 1, 4'h5, 32'hFFFFFFF0};
    vt[1] = '{32'h01F00003, 32'h104, 2'd0, 5'd0,  5'd0,  1, 0, 4'h3, 32'hFFFF0000};
    vt[2] = '{32'h80000010, 32'h108, 2'd2, 5'd0,  5'd0,  0, 0, 4'h0, 32'h00000001};
    vt[3] = '{32'hC2A00017, 32'h10C, 2'd3, 5'd0,  5'd0,  0, 0, 4'h7, 32'h000A0001};
    vt[4] = '{32'h0A123458, 32'h110, 2'd0, 5'd5,  5'd0,  1, 0, 4'h8, 32'h00012345};
    vt[5] = '{32'h5AB12340, 32'h114, 2'd1, 5'd13, 5'd11, 1, 1, 4'h0, 32'h00001234};
    vt[6] = '{32'hBFFFFFFF, 32'h118, 2'd2, 5'd0,  5'd0,  0, 0, 4'hF, 32'h03FFFFFF};

    step(1, 0, 0, 32'h0, 32'h0, 0, a);
    idle(1);
    check("reset_payload", payload, 82'h0);

    foreach (vt[i]) begin
      step(0, 0, 1, vt[i].instr, vt[i].pc, 1, a);
      idle(1);
      check("vec_pc", out_pc, vt[i].pc);
      check("vec_op", out_op, vt[i].op);
      check("vec_rs", out_rs, vt[i].rs);
      check("vec_rt", out_rt, vt[i].rt);
      check("vec_used", {out_rs_used, out_rt_used}, {vt[i].rsu, vt[i].rtu});
      check("vec_func", out_func, vt[i].func);
      check("vec_imm", out_imm, vt[i].imm);
    end
    idle(1);

    // Backpressure: four instructions, stall from the second cycle, then drain.
    bp[0] = 32'h464FFF05; bp[1] = 32'h01F00003; bp[2] = 32'h80000010; bp[3] = 32'h5AB12340;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      step(0, 0, 1, bp[idx], 32'h200 + 32'(idx) * 4, c == 0, a);
      if (a) idx++;
    end
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    for (int c = 0; c < 20 && (idx < 4 || q.size() > 0); c++) begin
      step(0, 0, idx < 4, bp[idx % 4], 32'h200 + 32'(idx % 4) * 4, 1, a);
      if (a) idx++;
    end
    check("bp_all_accepted", idx, 4);
    idle(1);
    idle(1);

    // Full throughput: one in and one out every cycle.
    for (int i = 0; i <= 16; i++) begin
      step(0, 0, i < 16, $urandom, 32'h300 + 32'(i) * 4, 1, a);
      if (i > 0) check("tp_out_valid", out_valid, 1);
      check("tp_in_ready", in_ready, 1);
    end
    idle(1);
    idle(1);

    // Flush with both entries full and a new instruction presented.
    step(0, 0, 1, 32'h464FFF05, 32'h400, 0, a);
    step(0, 0, 1, 32'h80000010, 32'h404, 0, a);
    step(0, 1, 1, 32'h01F00003, 32'h408, 0, a);
    check("pre_flush_skid_full", in_ready, 0);
    idle(1);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    idle(1);
    idle(1);

    // Reset mid-stream with both entries full.
    step(0, 0, 1, 32'h5AB12340, 32'h500, 0, a);
    step(0, 0, 1, 32'hC2A00017, 32'h504, 0, a);
    step(1, 0, 1, 32'h0A123458, 32'h508, 0, a);
    check("pre_reset_out_valid", out_valid, 1);
    idle(1);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_payload", payload, 82'h0);

    for (int i = 0; i < 800; i++) begin
      step(($urandom % 97) == 0, ($urandom % 23) == 0, ($urandom % 4) != 0, $urandom,
           32'h1000 + 32'(i) * 4, ($urandom % 3) != 0, a);
    end
    idle(1);
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised, registered instruction-decode pipeline stage between fetch and register-read.
- Splits each instruction word into opcode, source-register addresses, function code and a width-extended immediate.
- Adds per-format operand-use flags for the hazard unit, a valid/ready handshake with a 2-entry skid buffer, and a synchronous flush for branch redirects.

Parameters:
- XLEN, 32, instruction word width.
- DATA_W, 32, width of the extended immediate output; DATA_W >= XLEN-OPC_W-FUNC_W.
- OPC_W, 2, opcode field width at instr[XLEN-1 -: OPC_W].
- REG_W, 5, register-address field width.
- FUNC_W, 4, function-code field width at instr[FUNC_W-1:0].
- SHORT_IMM_W, 16, immediate width for the two-source format (op 1).
- PC_W, 32, width of the program-counter sideband.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  kill all held and incoming instructions this cycle.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept; registered, equals "skid entry empty".
- in_instr  in  XLEN  instruction word.
- in_pc  in  PC_W  PC of in_instr.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  downstream accepts.
- out_pc  out  PC_W  PC passed through.
- out_op  out  OPC_W  opcode.
- out_rs  out  REG_W  source register 1.
- out_rt  out  REG_W  source register 2.
- out_rs_used  out  1  out_rs is a real read.
- out_rt_used  out  1  out_rt is a real read.
- out_func  out  FUNC_W  function code.
- out_imm  out  DATA_W  extended immediate.

Behaviour:
- Field map, with LONG_W = XLEN-OPC_W-FUNC_W and T = instr[XLEN-OPC_W-1:FUNC_W]:
  - rs = instr[XLEN-OPC_W-1 -: REG_W]; rt = next REG_W bits down.
  - op 0: rs used, rt=0; imm = sign-extend T[LONG_W-REG_W-1:0] (21 bits at defaults).
  - op 1: rs and rt used; imm = sign-extend T[SHORT_IMM_W-1:0].
  - op 2 (jump): rs=rt=0; imm = zero-extend T[LONG_W-1:0].
  - op 3: rs=rt=0; imm as for op 0.
  - Unused register fields are forced to 0 and their *_used flag is 0.
  - func = instr[FUNC_W-1:0] for all ops.
- Decode is combinational on the input word; the result is captured into the output register. Latency is 1 cycle from the accept edge to out_valid.
- Handshake: transfer in on in_valid&&in_ready; transfer out on out_valid&&out_ready. The output payload is held stable while out_valid&&!out_ready. in_valid may not be retracted by fetch, but the stage does not depend on that.
- Skid buffer: one main output register plus one skid register (decoded form).
  - If the output register is occupied and not consumed, an accepted instruction goes to skid; in_ready drops next cycle.
  - When output is consumed and skid is full, skid moves to output the same edge; the new input is accepted only after in_ready rises.
  - Simultaneous consume and accept with skid empty: the new instruction loads the output register, giving full throughput of 1 per cycle.
  - Order is strictly preserved.
- Flush (synchronous, takes priority over every handshake): out_valid=0, skid cleared, in_ready=1 next cycle. An in_valid in the flush cycle is dropped.
- Reset: out_valid=0, skid empty, in_ready=1. All payload outputs are 0 (out_pc, out_op, out_rs, out_rt, *_used, out_func, out_imm). Reset has priority over flush.
- Payload registers update only on load; there are no X-propagating don't-cares on outputs.

Test Plan:
- Op 1 decode: in_instr=0x464FFF05, in_pc=0x100, out_ready=1 -> next cycle out_op=1, rs=3, rt=4, rs_used=1, rt_used=1, func=5, imm=0xFFFFFFF0, out_pc=0x100.
- Op 0 / op 2 sign rules: 0x01F00003 -> op=0, rs=0, rs_used=1, rt_used=0, imm=0xFFFF0000, func=3. Then 0x80000010 -> op=2, rs=rt=0, both used=0, imm=0x00000001, func=0.
- Backpressure: stream 4 instructions with out_ready=0 from cycle 2.
  - in_ready=0 after two are held.
  - Release out_ready: outputs appear in order, one per cycle, nothing lost or duplicated.
- Full throughput: in_valid=1 and out_ready=1 continuously for 16 cycles -> 16 outputs on consecutive cycles, in_ready constantly 1.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed and the incoming instruction never appear.
- Reset mid-stream with out_valid=1 and skid full -> next cycle out_valid=0, in_ready=1, all payload outputs 0.
